sub64_pipe: RTL and testbench
=============================

SUB64_PIPE -- requirements
Module: sub64_pipe

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits.
REQ-002 Parameter SPLIT, default 32: bit position where the carry chain is cut; lower stage handles bits [SPLIT-1:0].
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, as listed in REQ-004 and REQ-005.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 a  input  WIDTH  minuend, unsigned.
REQ-007 b  input  WIDTH  subtrahend, unsigned.
REQ-008 in_valid  input  1  a and b are valid this cycle.
REQ-009 in_ready  output  1  block accepts the operands this cycle.
REQ-010 q  output  WIDTH  difference a-b, modulo 2^WIDTH.
REQ-011 borrow  output  1  high when a < b (unsigned).
REQ-012 out_valid  output  1  q and borrow are valid.
REQ-013 out_ready  input  1  downstream accepts q this cycle.

Function
REQ-014 Two-stage pipeline with a valid bit per stage (s1_v, s2_v).
- Stage 1 registers lo = a[SPLIT-1:0]-b[SPLIT-1:0], the low borrow, and the upper halves of a and b.
- Stage 2 registers the upper difference with the stage-1 borrow as borrow-in, plus the final borrow.
REQ-015 Transfers happen only on a cycle where valid and ready are both high.
- Input transfer: in_valid & in_ready.
- Output transfer: out_valid & out_ready.
REQ-016 Stage-advance signals:
- adv2 = !s2_v | out_ready.
- adv1 = !s1_v | adv2.
- in_ready SHALL equal adv1; a combinational path from out_ready to in_ready is permitted.
REQ-017 out_valid SHALL equal s2_v; q and borrow SHALL be driven only from stage-2 registers.
REQ-018 Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held high.
- Throughput: one result per cycle.
REQ-019 Stall: while out_ready=0 and s2_v=1, stage 2 holds q/borrow stable.
- Stage 1 fills if empty; in_ready drops once both stages are full.
REQ-020 Simultaneous events: output transfer and input transfer in the same cycle SHALL both occur, with no bubble and no lost data.
REQ-021 Data registers SHALL NOT change when their stage does not advance.
REQ-022 Order SHALL be preserved; no result is duplicated or dropped.
REQ-023 Arithmetic wraps modulo 2^WIDTH; borrow is the true unsigned borrow out of bit WIDTH-1.

Reset
REQ-024 reset=0 SHALL asynchronously clear s1_v, s2_v, q, borrow, and all stage-1 data registers to 0.
REQ-025 Reset mid-operation discards all in-flight results.
- out_valid=0 from the reset edge onward.
- in_ready=1 on the first clock after reset deasserts.

Configuration
REQ-026 Macro SUB64_PIPE_SAT_EN:
- Defined: unsigned saturating subtract; when borrow=1, q SHALL be 0 and borrow still reports 1.
- Undefined: q is the wrapped difference.

Structure
REQ-027 Shared package sub64_pkg SHALL hold constants DEFAULT_WIDTH=64 and DEFAULT_SPLIT=32.
REQ-028 Sub-module sub_half (parameterised width, inputs x, y, bin; outputs d, bout) SHALL be instantiated once per stage.

Verification
REQ-029 a=100, b=58, in_valid=1 one cycle, out_ready=1 -> after 2 cycles out_valid=1, q=42, borrow=0, for exactly one cycle.
REQ-030 a=0x0000_0001_0000_0000, b=1 -> q=0x0000_0000_FFFF_FFFF, borrow=0; checks the borrow crossing SPLIT.
REQ-031 a=0, b=1 -> q=0xFFFF_FFFF_FFFF_FFFF, borrow=1 without SUB64_PIPE_SAT_EN; q=0, borrow=1 with it.
REQ-032 Stall and streaming:
- Stream 5 operand pairs back-to-back with out_ready=0 -> in_ready falls after 2 accepts; q holds the first result.
- Raise out_ready -> all 5 results emerge in order, one per cycle.
REQ-033 Reset mid-stream: reset=0 with both stages full -> out_valid=0 immediately, q=0; after release, new input a=7, b=7 -> q=0, borrow=0 two cycles later.
REQ-034 Random back-pressure on out_ready and random in_valid for 10k cycles -> scoreboard matches a-b in order with no loss or duplication.

Source files
------------

// File: rtl/sub64_pkg.sv
// Shared constants for the two-stage split-carry subtractor.
package sub64_pkg;

   localparam int DEFAULT_WIDTH = 64;
   localparam int DEFAULT_SPLIT = 32;

endpackage

// File: rtl/sub64_pipe_if.sv
// Operand/result handshake bundle for sub64_pipe; slave is the subtractor side.
interface sub64_pipe_if
   import sub64_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] q;
   logic             borrow;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output a, b, in_valid, out_ready,
      input  in_ready, q, borrow, out_valid
   );

   modport slave (
      input  a, b, in_valid, out_ready,
      output in_ready, q, borrow, out_valid
   );

endinterface

// File: rtl/sub_half.sv
// W-bit subtract with borrow-in; one instance per pipeline stage.
module sub_half #(
   parameter int W = 32
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);

   // One extra bit catches the borrow: x - y - bin is never below -2^W.
   logic [W:0] diff;

   assign diff = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
   assign d    = diff[W-1:0];
   assign bout = diff[W];

endmodule

// File: rtl/sub64_pipe.sv
// Two-stage pipelined unsigned subtractor, carry chain cut at SPLIT.
// Define SUB64_PIPE_SAT_EN to clamp negative results to zero.
module sub64_pipe
   import sub64_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SPLIT = DEFAULT_SPLIT
) (
   input  logic         clk,
   input  logic         reset,
   sub64_pipe_if.slave  bus
);

   localparam int HI = WIDTH - SPLIT;

   logic             s1_v_q,   s1_v_d;
   logic [SPLIT-1:0] s1_lo_q,  s1_lo_d;
   logic             s1_bor_q, s1_bor_d;
   logic [HI-1:0]    s1_ahi_q, s1_ahi_d;
   logic [HI-1:0]    s1_bhi_q, s1_bhi_d;

   logic             s2_v_q,   s2_v_d;
   logic [WIDTH-1:0] s2_q_q,   s2_q_d;
   logic             s2_bor_q, s2_bor_d;

   logic             adv1, adv2;
   logic [SPLIT-1:0] lo_diff;
   logic             lo_bout;
   logic [HI-1:0]    hi_diff;
   logic             hi_bout;

   sub_half #(.W(SPLIT)) u_lo (
      .x    (bus.a[SPLIT-1:0]),
      .y    (bus.b[SPLIT-1:0]),
      .bin  (1'b0),
      .d    (lo_diff),
      .bout (lo_bout)
   );

   sub_half #(.W(HI)) u_hi (
      .x    (s1_ahi_q),
      .y    (s1_bhi_q),
      .bin  (s1_bor_q),
      .d    (hi_diff),
      .bout (hi_bout)
   );

   always_comb begin
      adv2     = !s2_v_q || bus.out_ready;
      adv1     = !s1_v_q || adv2;

      s1_v_d   = s1_v_q;
      s1_lo_d  = s1_lo_q;
      s1_bor_d = s1_bor_q;
      s1_ahi_d = s1_ahi_q;
      s1_bhi_d = s1_bhi_q;
      s2_v_d   = s2_v_q;
      s2_q_d   = s2_q_q;
      s2_bor_d = s2_bor_q;

      if (adv1) begin
         s1_v_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_lo_d  = lo_diff;
            s1_bor_d = lo_bout;
            s1_ahi_d = bus.a[WIDTH-1:SPLIT];
            s1_bhi_d = bus.b[WIDTH-1:SPLIT];
         end
      end

      if (adv2) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_bor_d = hi_bout;
`ifdef SUB64_PIPE_SAT_EN
            s2_q_d   = hi_bout ? '0 : {hi_diff, s1_lo_q};
`else
            s2_q_d   = {hi_diff, s1_lo_q};
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_v_q   <= 1'b0;
         s1_lo_q  <= '0;
         s1_bor_q <= 1'b0;
         s1_ahi_q <= '0;
         s1_bhi_q <= '0;
         s2_v_q   <= 1'b0;
         s2_q_q   <= '0;
         s2_bor_q <= 1'b0;
      end else begin
         s1_v_q   <= s1_v_d;
         s1_lo_q  <= s1_lo_d;
         s1_bor_q <= s1_bor_d;
         s1_ahi_q <= s1_ahi_d;
         s1_bhi_q <= s1_bhi_d;
         s2_v_q   <= s2_v_d;
         s2_q_q   <= s2_q_d;
         s2_bor_q <= s2_bor_d;
      end
   end

   // Ready looks through both stages so a draining pipe accepts every cycle.
   assign bus.in_ready  = adv1;
   assign bus.out_valid = s2_v_q;
   assign bus.q         = s2_q_q;
   assign bus.borrow    = s2_bor_q;

endmodule

// File: tb/tb_sub64_pipe.sv
// Directed + random bench for sub64_pipe with an in-order reference queue.
module tb_sub64_pipe;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   sub64_pipe_if #(.WIDTH(64)) bus ();

   sub64_pipe #(.WIDTH(64), .SPLIT(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_out  = 0;

   logic [127:0] sb[$];
   logic         ir_s, ov_s, br_s;
   logic [63:0]  q_s;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] ref_q(input logic [63:0] x, input logic [63:0] y);
`ifdef SUB64_PIPE_SAT_EN
      if (x < y) return 64'd0;
`endif
      return x - y;
   endfunction

   // Drive one cycle at the falling edge, sample just after, score transfers
   // that the next rising edge will complete.
   task automatic cyc(input logic iv, input logic [63:0] av, input logic [63:0] bv,
                      input logic ordy);
      logic [127:0] e;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.a         = av;
      bus.b         = bv;
      bus.out_ready = ordy;
      #1;
      ir_s = bus.in_ready;
      ov_s = bus.out_valid;
      q_s  = bus.q;
      br_s = bus.borrow;
      if (ov_s && ordy) begin
         n_out++;
         if (sb.size() == 0) chk("spurious_out", 64'd1, 64'd0);
         else begin
            e = sb.pop_front();
            chk("sb_q", q_s, ref_q(e[127:64], e[63:0]));
            chk("sb_borrow", {63'd0, br_s}, {63'd0, e[127:64] < e[63:0]});
         end
      end
      if (iv && ir_s) sb.push_back({av, bv});
   endtask

   logic [63:0] pa[5];
   logic [63:0] pb[5];

   initial begin
      int acc;
      logic [63:0] ra, rb;

      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_q", bus.q, 64'd0);
      chk("rst_borrow", {63'd0, bus.borrow}, 64'd0);
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      reset = 1'b1;

      // Single transaction latency and one-cycle output pulse
      cyc(1, 64'd100, 64'd58, 1);
      cyc(0, 0, 0, 1);
      chk("lat_c1_valid", {63'd0, ov_s}, 64'd0);
      cyc(0, 0, 0, 1);
      chk("lat_c2_valid", {63'd0, ov_s}, 64'd1);
      chk("lat_q", q_s, 64'd42);
      chk("lat_borrow", {63'd0, br_s}, 64'd0);
      cyc(0, 0, 0, 1);
      chk("lat_c3_valid", {63'd0, ov_s}, 64'd0);

      // Borrow crossing the split point
      cyc(1, 64'h0000_0001_0000_0000, 64'd1, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("split_q", q_s, 64'h0000_0000_FFFF_FFFF);
      chk("split_borrow", {63'd0, br_s}, 64'd0);

      // Full underflow
      cyc(1, 64'd0, 64'd1, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
`ifdef SUB64_PIPE_SAT_EN
      chk("under_q", q_s, 64'd0);
`else
      chk("under_q", q_s, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
      chk("under_borrow", {63'd0, br_s}, 64'd1);

      // Stall then stream
      pa = '{64'd1000, 64'd2007, 64'd5, 64'd4021, 64'hFFFF_0000_0000_0000};
      pb = '{64'd1, 64'd333, 64'd9, 64'd999, 64'h0000_0001_0000_0001};
      acc = 0;
      for (int k = 0; k < 5; k++) begin
         cyc(1, pa[acc], pb[acc], 0);
         if (ir_s) acc++;
      end
      chk("stall_accepts", 64'(acc), 64'd2);
      chk("stall_in_ready", {63'd0, ir_s}, 64'd0);
      chk("stall_valid", {63'd0, ov_s}, 64'd1);
      chk("stall_q_hold", q_s, ref_q(pa[0], pb[0]));
      n_out = 0;
      for (int k = 0; k < 5; k++) begin
         cyc(acc < 5, pa[acc < 5 ? acc : 0], pb[acc < 5 ? acc : 0], 1);
         if (acc < 5 && ir_s) acc++;
      end
      chk("stream_outs", 64'(n_out), 64'd5);
      chk("stream_accepts", 64'(acc), 64'd5);
      cyc(0, 0, 0, 1);
      chk("stream_drained", 64'(sb.size()), 64'd0);

      // Reset with both stages full
      cyc(1, 64'd11, 64'd3, 0);
      cyc(1, 64'd12, 64'd4, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("mid_rst_q", bus.q, 64'd0);
      sb.delete();
      #1 reset = 1'b1;
      cyc(1, 64'd7, 64'd7, 1);
      chk("post_rst_ready", {63'd0, ir_s}, 64'd1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("post_rst_valid", {63'd0, ov_s}, 64'd1);
      chk("post_rst_q", q_s, 64'd0);
      chk("post_rst_borrow", {63'd0, br_s}, 64'd0);

      // Random traffic with random back-pressure
      for (int k = 0; k < 10000; k++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: rb = ra;
            1: rb = {ra[63:32], $urandom};
            2: ra = {32'd0, ra[31:0]};
            default: ;
         endcase
         cyc($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 9) < 7);
      end
      for (int k = 0; k < 10; k++) cyc(0, 0, 0, 1);
      chk("rand_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
